core_regwr_arbiter: RTL and testbench

CORE_REGWR_ARBITER -- requirements
Module: core_regwr_arbiter

---
 rtl/core_regwr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_core_regwr_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_regwr_arbiter.sv
// core_regwr_arbiter: two-source register-file write arbiter with starvation guard.
//
// Port A is the in-order pipeline writeback and normally has priority. Port B is a
// long-latency unit that holds its request until b_ready. If B waits too long, the
// arbiter stalls the pipeline (o_stall_a) for one grant so B can drain.
// The accepted request is registered onto the write port with one cycle of latency.
// Writes to x0 are accepted but never drive o_we.
//
// Optional build macro CORE_REGWR_SCOREBOARD_EN adds a pending-destination scoreboard.
// Without it, o_busy1/o_busy2 read 0.
//
// Parameters:
//   STARVE_LIMIT  cycles B may wait before port A is stalled (2..15)
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   a_valid, a_addr, a_data        pipeline writeback request
//   b_valid, b_addr, b_data        long-latency writeback request
//   b_ready                        B accepted this cycle (combinational)
//   o_stall_a                      freeze pipeline, A not accepted
//   o_we, o_waddr, o_wdata         registered regfile write port
//   sb_set, sb_addr                mark destination pending (long op issued)
//   rs1, rs2, o_busy1, o_busy2     hazard query, state before the current edge
`timescale 1ns/1ps
module core_regwr_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        o_stall_a,
  output logic        o_we,
  output logic [4:0]  o_waddr,
  output logic [31:0] o_wdata,
  input  logic        sb_set,
  input  logic [4:0]  sb_addr,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        o_busy1,
  output logic        o_busy2
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StForce = 2'd2;

  localparam logic [3:0] LimitM1 = 4'(STARVE_LIMIT - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;
  logic        a_accept;

  // Stall is decoded from state only, so it has no combinational input path.
  assign o_stall_a = (state_q == StForce);

  // Gate with rst so no grant is visible while reset is held.
  assign a_accept = !rst && a_valid && !o_stall_a;
  assign b_ready  = !rst && b_valid && (!a_valid || o_stall_a);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (b_valid && a_valid) begin
          state_d = StWait;
          cnt_d   = 4'd1;
        end else begin
          cnt_d = 4'd0;
        end
      end
      StWait: begin
        if (b_ready || !b_valid) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LimitM1) begin
            state_d = StForce;
          end
        end
      end
      StForce: begin
        if (b_ready || !b_valid) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write port: x0 targets are consumed but suppressed at o_we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
    end else begin
      we_q <= (a_accept && (a_addr != 5'd0)) || (b_ready && (b_addr != 5'd0));
      if (a_accept) begin
        waddr_q <= a_addr;
        wdata_q <= a_data;
      end else if (b_ready) begin
        waddr_q <= b_addr;
        wdata_q <= b_data;
      end
    end
  end

  assign o_we    = we_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;

`ifdef CORE_REGWR_SCOREBOARD_EN
  logic [31:0] pending_q, pending_d;

  // Set is applied after clear so a same-cycle set wins; x0 is never pending.
  always_comb begin
    pending_d = pending_q;
    if (b_ready) begin
      pending_d[b_addr] = 1'b0;
    end
    if (sb_set) begin
      pending_d[sb_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 32'd0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign o_busy1 = pending_q[rs1];
  assign o_busy2 = pending_q[rs2];
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set, sb_addr, rs1, rs2};
  assign o_busy1   = 1'b0;
  assign o_busy2   = 1'b0;
`endif

endmodule

// File: tb/tb_core_regwr_arbiter.sv
// Scoreboard bench for core_regwr_arbiter: the stimulus process pushes expected
// write-port transactions (tagged with the cycle they must appear in) and the
// expected combinational outputs; a monitor compares on every falling edge and
// on explicit sample events used for the asynchronous reset check.
`timescale 1ns/1ps
module tb_core_regwr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic [4:0]  a_addr = '0;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic [4:0]  b_addr = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic        o_stall_a;
  logic        o_we;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_addr = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        o_busy1;
  logic        o_busy2;

`ifdef CORE_REGWR_SCOREBOARD_EN
  localparam bit SbEn = 1'b1;
`else
  localparam bit SbEn = 1'b0;
`endif

  core_regwr_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .o_stall_a(o_stall_a),
    .o_we     (o_we),
    .o_waddr  (o_waddr),
    .o_wdata  (o_wdata),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .rs1      (rs1),
    .rs2      (rs2),
    .o_busy1  (o_busy1),
    .o_busy2  (o_busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wq[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        chk_comb = 1'b0;
  logic        exp_bready = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_busy1 = 1'b0;
  logic        exp_busy2 = 1'b0;
  logic        done = 1'b0;
  event        sample_ev;

  always @(posedge clk) cyc <= cyc + 1;

  // Only the monitor calls this, so it is the sole writer of the counters.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)", name, act, exp, cyc,
               $time);
    end
  endtask

  // One stimulus cycle; the bench decides from its own expectations which write lands.
  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic ebr, input logic est, input logic commit);
    wr_t w;
    @(posedge clk);
    #1;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    sb_set = 1'b0; sb_addr = '0; rs1 = '0; rs2 = '0;
    exp_bready = ebr; exp_stall = est;
    exp_busy1 = 1'b0; exp_busy2 = 1'b0;
    chk_comb = 1'b1;
    if (commit) begin
      w.cyc = cyc + 1;
      if (av && !est) begin
        w.addr = aa; w.data = ad;
        if (aa != 5'd0) wq.push_back(w);
      end else if (ebr) begin
        w.addr = ba; w.data = bd;
        if (ba != 5'd0) wq.push_back(w);
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Scoreboard inputs for the cycle just driven; expectations collapse to 0 without it.
  task automatic sb(input logic set, input logic [4:0] sa, input logic [4:0] r1,
                    input logic e1, input logic [4:0] r2, input logic e2);
    sb_set = set; sb_addr = sa; rs1 = r1; rs2 = r2;
    exp_busy1 = SbEn & e1;
    exp_busy2 = SbEn & e2;
  endtask

  initial begin : monitor
    wr_t w;
    forever begin
      @(negedge clk or sample_ev);
      if (done) begin
        chk("queue_drained", 32'(wq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end else if (rst) begin
        chk("rst_we", 32'(o_we), 32'd0);
        chk("rst_waddr", 32'(o_waddr), 32'd0);
        chk("rst_wdata", o_wdata, 32'd0);
        chk("rst_stall", 32'(o_stall_a), 32'd0);
        chk("rst_bready", 32'(b_ready), 32'd0);
        chk("rst_busy1", 32'(o_busy1), 32'd0);
        chk("rst_busy2", 32'(o_busy2), 32'd0);
      end else begin
        if (chk_comb) begin
          chk("b_ready", 32'(b_ready), 32'(exp_bready));
          chk("stall_a", 32'(o_stall_a), 32'(exp_stall));
          chk("busy1", 32'(o_busy1), 32'(exp_busy1));
          chk("busy2", 32'(o_busy2), 32'(exp_busy2));
        end
        while (wq.size() > 0 && wq[0].cyc < cyc) begin
          chk("write_missing_cycle", cyc, wq[0].cyc);
          w = wq.pop_front();
        end
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
          w = wq.pop_front();
          chk("we", 32'(o_we), 32'd1);
          chk("waddr", 32'(o_waddr), 32'(w.addr));
          chk("wdata", o_wdata, w.data);
        end else begin
          chk("we_idle", 32'(o_we), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Lone A, lone B, idle, x0 write, full-width data.
    drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAB, 1'b1, 1'b0, 1'b1);
    idle();
    drive(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    idle();

    // Starvation: A wins four cycles, then B is forced through.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b1, 5'd3, 32'hB3, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 5'd20, 32'h200, 1'b1, 5'd3, 32'hB3, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 5'd20, 32'h200, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // B withdrawing while waiting restarts the count.
    for (int i = 0; i < 2; i++)
      drive(1'b1, 5'(14 + i), 32'h300 + 32'(i), 1'b1, 5'd6, 32'hB6, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 5'd16, 32'h302, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      drive(1'b1, 5'(17 + i), 32'h400 + 32'(i), 1'b1, 5'd6, 32'hB6, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 5'd21, 32'h404, 1'b1, 5'd6, 32'hB6, 1'b1, 1'b1, 1'b1);
    idle();

    // Scoreboard: set, no bypass, clear on B commit, set wins over clear, x0 ignored.
    idle(); sb(1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0);
    idle(); sb(1'b0, 5'd0, 5'd9, 1'b1, 5'd9, 1'b1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 1'b1);
    sb(1'b0, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0);
    idle(); sb(1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h77, 1'b1, 1'b0, 1'b1);
    sb(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    idle(); sb(1'b1, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0);
    idle(); sb(1'b0, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0);

    // Reset asserted mid-FORCE: the pending B grant must be discarded.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 5'(1 + i), 32'h500 + 32'(i), 1'b1, 5'd4, 32'hC4, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 32'hC4, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 ->sample_ev;
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk_comb = 1'b0;

    // Pending bit 9 was set before reset and must now read clear.
    idle(); sb(1'b0, 5'd0, 5'd9, 1'b0, 5'd9, 1'b0);
    drive(1'b1, 5'd2, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    idle();
    idle();

    @(posedge clk);
    #1 done = 1'b1;
    ->sample_ev;
  end

endmodule
